// File: rtl/buffer_proc_arbiter_pkg.sv
// Shared constants, FSM encoding and requester IDs for the frame-buffer
// processing-port arbiter.
package buffer_proc_arbiter_pkg;

   localparam int IMG_W         = 160;
   localparam int IMG_H         = 120;
   // The slot just past the visible image holds the black pixel.
   localparam int IMG_LAST      = IMG_W * IMG_H;

   localparam int DEF_AW        = 15;
   localparam int DEF_DW        = 12;
   localparam int DEF_MAX_BURST = 16;

   typedef enum logic [1:0] {
      ST_RR     = 2'd0,
      ST_LOCKED = 2'd1,
      ST_YIELD  = 2'd2
   } arb_state_e;

   localparam logic REQ_CPU = 1'b0;
   localparam logic REQ_PRC = 1'b1;

   function automatic logic addr_in_range(input logic [31:0] addr, input logic [31:0] last);
      return addr <= last;
   endfunction

endpackage

// File: rtl/buffer_proc_arbiter_if.sv
// Requester, memory-port and hold signals of the processing-port arbiter.
// The slave view belongs to the arbiter, the master view to its environment.
interface buffer_proc_arbiter_if #(
   parameter int AW = buffer_proc_arbiter_pkg::DEF_AW,
   parameter int DW = buffer_proc_arbiter_pkg::DEF_DW
);
   logic          cpu_req;
   logic [AW-1:0] cpu_addr;
   logic          cpu_gnt;
   logic          cpu_rvalid;
   logic [DW-1:0] cpu_rdata;
   logic          cpu_err;

   logic          prc_req;
   logic          prc_lock;
   logic [AW-1:0] prc_addr;
   logic          prc_gnt;
   logic          prc_rvalid;
   logic [DW-1:0] prc_rdata;
   logic          prc_err;

   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_data;
   logic          wr_hold;

   modport master (
      output cpu_req, cpu_addr, prc_req, prc_lock, prc_addr, mem_data,
      input  cpu_gnt, cpu_rvalid, cpu_rdata, cpu_err,
      input  prc_gnt, prc_rvalid, prc_rdata, prc_err,
      input  mem_addr, wr_hold
   );

   modport slave (
      input  cpu_req, cpu_addr, prc_req, prc_lock, prc_addr, mem_data,
      output cpu_gnt, cpu_rvalid, cpu_rdata, cpu_err,
      output prc_gnt, prc_rvalid, prc_rdata, prc_err,
      output mem_addr, wr_hold
   );
endinterface

// File: rtl/buffer_proc_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: a lone request wins, a tie goes to the
// requester that was not granted last.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic [1:0] gnt
);
   for (genvar gi = 0; gi < 2; gi++) begin : g_gnt
      assign gnt[gi] = req[gi] & (~req[1-gi] | (last_grant != 1'(gi)));
   end
endmodule

// File: rtl/buffer_proc_arbiter.sv
// Shares the frame buffer's combinational processing read port between the
// CPU and the scanner, with scanner lock sessions that raise wr_hold.
module buffer_proc_arbiter #(
   parameter int AW        = buffer_proc_arbiter_pkg::DEF_AW,
   parameter int DW        = buffer_proc_arbiter_pkg::DEF_DW,
   parameter int IMG_LAST  = buffer_proc_arbiter_pkg::IMG_LAST,
   parameter int MAX_BURST = buffer_proc_arbiter_pkg::DEF_MAX_BURST
) (
   input  logic                 clk,
   input  logic                 rst_n,
   buffer_proc_arbiter_if.slave bus
);
   import buffer_proc_arbiter_pkg::*;

   localparam int CW = $clog2(MAX_BURST + 1);

   arb_state_e    state_q, state_d;
   logic          last_grant_q, last_grant_d;
   logic [CW-1:0] burst_q, burst_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic          wr_hold_q, wr_hold_d;
   logic          cpu_rvalid_q, cpu_rvalid_d;
   logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
   logic          cpu_err_q, cpu_err_d;
   logic          prc_rvalid_q, prc_rvalid_d;
   logic [DW-1:0] prc_rdata_q, prc_rdata_d;
   logic          prc_err_q, prc_err_d;

   logic [1:0]    rr_gnt;
   logic [1:0]    gnt;
   logic          burst_at_max;
   logic          in_range;
   logic [DW-1:0] resp_data;

   rr_arb2 u_rr_arb2 (
      .req        ({bus.prc_req, bus.cpu_req}),
      .last_grant (last_grant_q),
      .gnt        (rr_gnt)
   );

   assign burst_at_max = (burst_q >= CW'(MAX_BURST));

   always_comb begin
      gnt     = 2'b00;
      state_d = state_q;
      burst_d = burst_q;
      unique case (state_q)
         ST_RR: begin
            gnt = rr_gnt;
            // The lock only takes hold once the scanner actually wins a slot.
            if (rr_gnt[REQ_PRC] && bus.prc_lock) begin
               state_d = ST_LOCKED;
               burst_d = CW'(1);
            end
         end
         ST_LOCKED: begin
            if (!bus.prc_lock) begin
               gnt     = rr_gnt;
               state_d = ST_RR;
               burst_d = '0;
            end else if (!bus.prc_req) begin
               gnt[REQ_CPU] = bus.cpu_req;
            end else if (burst_at_max && bus.cpu_req) begin
               state_d = ST_YIELD;
            end else begin
               gnt[REQ_PRC] = 1'b1;
               if (!burst_at_max) begin
                  burst_d = burst_q + CW'(1);
               end
            end
         end
         ST_YIELD: begin
            gnt[REQ_CPU] = bus.cpu_req;
            burst_d      = '0;
            state_d      = bus.prc_lock ? ST_LOCKED : ST_RR;
         end
         default: begin
            state_d = ST_RR;
            burst_d = '0;
         end
      endcase
      // Keep every output quiet while reset is held, including the grants.
      if (!rst_n) begin
         gnt = 2'b00;
      end
   end

   always_comb begin
      mem_addr_d   = mem_addr_q;
      last_grant_d = last_grant_q;
      if (gnt[REQ_CPU]) begin
         mem_addr_d   = bus.cpu_addr;
         last_grant_d = REQ_CPU;
      end else if (gnt[REQ_PRC]) begin
         mem_addr_d   = bus.prc_addr;
         last_grant_d = REQ_PRC;
      end

      in_range  = addr_in_range(32'(mem_addr_d), 32'(IMG_LAST));
      resp_data = in_range ? bus.mem_data : '0;

      cpu_rvalid_d = gnt[REQ_CPU];
      cpu_rdata_d  = gnt[REQ_CPU] ? resp_data : cpu_rdata_q;
      cpu_err_d    = gnt[REQ_CPU] ? !in_range : cpu_err_q;
      prc_rvalid_d = gnt[REQ_PRC];
      prc_rdata_d  = gnt[REQ_PRC] ? resp_data : prc_rdata_q;
      prc_err_d    = gnt[REQ_PRC] ? !in_range : prc_err_q;

      wr_hold_d = (state_d != ST_RR);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_RR;
         last_grant_q <= REQ_PRC;
         burst_q      <= '0;
         mem_addr_q   <= '0;
         wr_hold_q    <= 1'b0;
         cpu_rvalid_q <= 1'b0;
         cpu_rdata_q  <= '0;
         cpu_err_q    <= 1'b0;
         prc_rvalid_q <= 1'b0;
         prc_rdata_q  <= '0;
         prc_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         burst_q      <= burst_d;
         mem_addr_q   <= mem_addr_d;
         wr_hold_q    <= wr_hold_d;
         cpu_rvalid_q <= cpu_rvalid_d;
         cpu_rdata_q  <= cpu_rdata_d;
         cpu_err_q    <= cpu_err_d;
         prc_rvalid_q <= prc_rvalid_d;
         prc_rdata_q  <= prc_rdata_d;
         prc_err_q    <= prc_err_d;
      end
   end

   assign bus.cpu_gnt    = gnt[REQ_CPU];
   assign bus.prc_gnt    = gnt[REQ_PRC];
   assign bus.mem_addr   = mem_addr_d;
   assign bus.wr_hold    = wr_hold_q;
   assign bus.cpu_rvalid = cpu_rvalid_q;
   assign bus.cpu_rdata  = cpu_rdata_q;
   assign bus.cpu_err    = cpu_err_q;
   assign bus.prc_rvalid = prc_rvalid_q;
   assign bus.prc_rdata  = prc_rdata_q;
   assign bus.prc_err    = prc_err_q;

endmodule

// File: tb/tb_buffer_proc_arbiter.sv
// Directed bench for buffer_proc_arbiter; the frame buffer is stood in for by
// mem_data = mem_addr[11:0] ^ 12'hAD8 so expected pixels are hand-computable.
module tb_buffer_proc_arbiter;

   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   buffer_proc_arbiter_if #(.AW(15), .DW(12)) bus_if ();

   buffer_proc_arbiter dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   assign bus_if.mem_data = bus_if.mem_addr[11:0] ^ 12'hAD8;

   always @(negedge clk) begin
      if (bus_if.cpu_rvalid)
         $display("cpu read  addr=%0d data=%h err=%b", bus_if.mem_addr, bus_if.cpu_rdata, bus_if.cpu_err);
      if (bus_if.prc_rvalid)
         $display("prc read  data=%h err=%b wr_hold=%b", bus_if.prc_rdata, bus_if.prc_err, bus_if.wr_hold);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n           = 1'b0;
      bus_if.cpu_req  = 1'b0;
      bus_if.cpu_addr = '0;
      bus_if.prc_req  = 1'b0;
      bus_if.prc_lock = 1'b0;
      bus_if.prc_addr = '0;

      // Reset state
      cyc();
      chk("rst_cpu_gnt",    32'(bus_if.cpu_gnt),    32'd0);
      chk("rst_prc_gnt",    32'(bus_if.prc_gnt),    32'd0);
      chk("rst_cpu_rvalid", 32'(bus_if.cpu_rvalid), 32'd0);
      chk("rst_prc_rvalid", 32'(bus_if.prc_rvalid), 32'd0);
      chk("rst_cpu_rdata",  32'(bus_if.cpu_rdata),  32'd0);
      chk("rst_wr_hold",    32'(bus_if.wr_hold),    32'd0);
      chk("rst_mem_addr",   32'(bus_if.mem_addr),   32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Tie after reset: CPU, PRC, CPU
      bus_if.cpu_req = 1'b1; bus_if.cpu_addr = 15'd5;
      bus_if.prc_req = 1'b1; bus_if.prc_addr = 15'd6;
      #1;
      chk("tie0_cpu_gnt",  32'(bus_if.cpu_gnt),  32'd1);
      chk("tie0_prc_gnt",  32'(bus_if.prc_gnt),  32'd0);
      chk("tie0_mem_addr", 32'(bus_if.mem_addr), 32'd5);
      cyc();
      chk("tie1_cpu_rvalid", 32'(bus_if.cpu_rvalid), 32'd1);
      chk("tie1_cpu_rdata",  32'(bus_if.cpu_rdata),  32'h0ADD);
      chk("tie1_prc_gnt",    32'(bus_if.prc_gnt),    32'd1);
      chk("tie1_cpu_gnt",    32'(bus_if.cpu_gnt),    32'd0);
      chk("tie1_mem_addr",   32'(bus_if.mem_addr),   32'd6);
      cyc();
      chk("tie2_prc_rvalid", 32'(bus_if.prc_rvalid), 32'd1);
      chk("tie2_prc_rdata",  32'(bus_if.prc_rdata),  32'h0ADE);
      chk("tie2_cpu_rvalid", 32'(bus_if.cpu_rvalid), 32'd0);
      chk("tie2_cpu_gnt",    32'(bus_if.cpu_gnt),    32'd1);
      cyc();
      bus_if.cpu_req = 1'b0; bus_if.prc_req = 1'b0;
      #1;
      chk("tie3_cpu_rvalid",    32'(bus_if.cpu_rvalid), 32'd1);
      chk("tie3_prc_rvalid",    32'(bus_if.prc_rvalid), 32'd0);
      chk("tie3_mem_addr_hold", 32'(bus_if.mem_addr),   32'd5);
      cyc();
      chk("tie4_cpu_rvalid_pulse", 32'(bus_if.cpu_rvalid), 32'd0);

      // Single CPU read
      bus_if.cpu_req = 1'b1; bus_if.cpu_addr = 15'd100;
      #1;
      chk("rd_cpu_gnt",  32'(bus_if.cpu_gnt),  32'd1);
      chk("rd_mem_addr", 32'(bus_if.mem_addr), 32'd100);
      cyc();
      bus_if.cpu_req = 1'b0;
      #1;
      chk("rd_cpu_rvalid", 32'(bus_if.cpu_rvalid), 32'd1);
      chk("rd_cpu_rdata",  32'(bus_if.cpu_rdata),  32'h0ABC);
      chk("rd_cpu_err",    32'(bus_if.cpu_err),    32'd0);

      // Range check on the scanner port
      bus_if.prc_req = 1'b1; bus_if.prc_addr = 15'd19200;
      #1;
      chk("rng_prc_gnt", 32'(bus_if.prc_gnt), 32'd1);
      cyc();
      bus_if.prc_addr = 15'd19201;
      #1;
      chk("rng19200_rvalid", 32'(bus_if.prc_rvalid), 32'd1);
      chk("rng19200_rdata",  32'(bus_if.prc_rdata),  32'h01D8);
      chk("rng19200_err",    32'(bus_if.prc_err),    32'd0);
      chk("rng19201_addr",   32'(bus_if.mem_addr),   32'd19201);
      cyc();
      bus_if.prc_addr = 15'd32767;
      #1;
      chk("rng19201_rdata", 32'(bus_if.prc_rdata), 32'd0);
      chk("rng19201_err",   32'(bus_if.prc_err),   32'd1);
      cyc();
      bus_if.prc_req = 1'b0;
      #1;
      chk("rng32767_rvalid", 32'(bus_if.prc_rvalid), 32'd1);
      chk("rng32767_rdata",  32'(bus_if.prc_rdata),  32'd0);
      chk("rng32767_err",    32'(bus_if.prc_err),    32'd1);
      chk("rng_addr_hold",   32'(bus_if.mem_addr),   32'd32767);
      cyc();
      chk("rng_rvalid_pulse", 32'(bus_if.prc_rvalid), 32'd0);

      // Lock burst: CPU takes one slot first so the scanner wins the tie
      bus_if.cpu_req = 1'b1; bus_if.cpu_addr = 15'd300;
      #1;
      chk("lk_pre_cpu_gnt", 32'(bus_if.cpu_gnt), 32'd1);
      cyc();
      bus_if.prc_req = 1'b1; bus_if.prc_lock = 1'b1; bus_if.prc_addr = 15'd200;
      #1;
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("lk_burst%0d_prc_gnt", i), 32'(bus_if.prc_gnt), 32'd1);
         chk($sformatf("lk_burst%0d_cpu_gnt", i), 32'(bus_if.cpu_gnt), 32'd0);
         chk($sformatf("lk_burst%0d_wr_hold", i), 32'(bus_if.wr_hold), 32'(i > 0));
         if (i == 1)
            chk("lk_prc_rdata", 32'(bus_if.prc_rdata), 32'h0A10);
         cyc();
         #1;
      end
      chk("lk_yield_entry_prc_gnt", 32'(bus_if.prc_gnt), 32'd0);
      chk("lk_yield_entry_cpu_gnt", 32'(bus_if.cpu_gnt), 32'd0);
      chk("lk_yield_entry_wr_hold", 32'(bus_if.wr_hold), 32'd1);
      cyc();
      #1;
      chk("lk_yield_cpu_gnt",  32'(bus_if.cpu_gnt),  32'd1);
      chk("lk_yield_prc_gnt",  32'(bus_if.prc_gnt),  32'd0);
      chk("lk_yield_mem_addr", 32'(bus_if.mem_addr), 32'd300);
      chk("lk_yield_wr_hold",  32'(bus_if.wr_hold),  32'd1);
      cyc();
      bus_if.cpu_req = 1'b0;
      #1;
      chk("lk_after_yield_cpu_rdata", 32'(bus_if.cpu_rdata), 32'h0BF4);
      chk("lk_after_yield_prc_gnt",   32'(bus_if.prc_gnt),   32'd1);
      for (int i = 0; i < 2; i++) begin
         cyc();
         #1;
         chk($sformatf("lk_again%0d_prc_gnt", i), 32'(bus_if.prc_gnt), 32'd1);
      end

      // Locked but scanner idle: CPU still served, hold stays up
      cyc();
      bus_if.prc_req = 1'b0; bus_if.cpu_req = 1'b1; bus_if.cpu_addr = 15'd100;
      #1;
      chk("lk_idle_cpu_gnt", 32'(bus_if.cpu_gnt), 32'd1);
      chk("lk_idle_prc_gnt", 32'(bus_if.prc_gnt), 32'd0);
      chk("lk_idle_wr_hold", 32'(bus_if.wr_hold), 32'd1);
      cyc();
      bus_if.cpu_req = 1'b0; bus_if.prc_req = 1'b1;
      #1;
      chk("lk_resume_prc_gnt", 32'(bus_if.prc_gnt), 32'd1);
      cyc();
      #1;
      chk("lk_fifth_prc_gnt", 32'(bus_if.prc_gnt), 32'd1);

      // Lock release
      cyc();
      bus_if.prc_lock = 1'b0;
      #1;
      chk("rel_prc_gnt", 32'(bus_if.prc_gnt), 32'd1);
      chk("rel_wr_hold", 32'(bus_if.wr_hold), 32'd1);
      cyc();
      bus_if.prc_req = 1'b0;
      #1;
      chk("rel1_wr_hold", 32'(bus_if.wr_hold), 32'd0);
      cyc();
      #1;
      chk("rel2_wr_hold", 32'(bus_if.wr_hold), 32'd0);

      // Tie after release goes to the CPU; then async reset before its rvalid
      bus_if.cpu_req = 1'b1; bus_if.cpu_addr = 15'd100;
      bus_if.prc_req = 1'b1; bus_if.prc_addr = 15'd6;
      #1;
      chk("rr_tie_cpu_gnt", 32'(bus_if.cpu_gnt), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst_cpu_gnt",   32'(bus_if.cpu_gnt),   32'd0);
      chk("arst_prc_gnt",   32'(bus_if.prc_gnt),   32'd0);
      chk("arst_cpu_rdata", 32'(bus_if.cpu_rdata), 32'd0);
      chk("arst_prc_rdata", 32'(bus_if.prc_rdata), 32'd0);
      chk("arst_mem_addr",  32'(bus_if.mem_addr),  32'd0);
      chk("arst_wr_hold",   32'(bus_if.wr_hold),   32'd0);
      cyc();
      chk("arst_cpu_rvalid", 32'(bus_if.cpu_rvalid), 32'd0);
      rst_n = 1'b1;
      #1;
      chk("arst_rel_cpu_rvalid", 32'(bus_if.cpu_rvalid), 32'd0);
      chk("arst_rel_cpu_gnt",    32'(bus_if.cpu_gnt),    32'd1);
      chk("arst_rel_prc_gnt",    32'(bus_if.prc_gnt),    32'd0);
      cyc();
      bus_if.cpu_req = 1'b0; bus_if.prc_req = 1'b0;
      #1;
      chk("arst_new_cpu_rvalid", 32'(bus_if.cpu_rvalid), 32'd1);
      chk("arst_new_cpu_rdata",  32'(bus_if.cpu_rdata),  32'h0ABC);
      cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
